slave_fifo_responder: RTL and testbench
=======================================

// Module: slave_fifo_responder
// PURPOSE
//  Target-side model of the 16-bit synchronous slave-FIFO bus: the end that answers a bus master driving
//  SLOE/SLRD/SLWR/FIFOADR/PKTEND.
//  Holds an OUT endpoint (ADR 2'b00, master reads) and an IN endpoint (ADR 2'b10, master writes).
//  Exposes local push/pop ports to the board logic. Used as bench/bring-up stand-in for the USB controller
//  and for board-to-board links.
// PARAMETERS
//  AW     9   log2 endpoint depth (512 words per endpoint)
//  DW     16  bus/data width
// PORTS
//  CLK          in   1   bus clock; single clock domain
//  RST          in   1   asynchronous, active-low reset
//  SLOE         in   1   1 = master releases FD, responder may drive
//  SLRD         in   1   1 = pop one word from OUT endpoint this edge
//  SLWR         in   1   1 = push FD into IN endpoint this edge
//  FIFOADR      in   2   endpoint select: 00 OUT, 10 IN; 01/11 reserved
//  PKTEND       in   1   1 with SLWR = word is last of packet
//  FD           inout 16 bus data
//  FLAG_EMPTY   out  1   1 = OUT endpoint empty (independent of FIFOADR)
//  FLAG_FULL    out  1   1 = IN endpoint full (independent of FIFOADR)
//  tx_data      in   16  local word for OUT endpoint
//  tx_wrreq     in   1   push tx_data
//  tx_full      out  1   OUT endpoint full
//  rx_q         out  17  {last, data} head of IN endpoint (first-word-fall-through)
//  rx_rdrq      in   1   pop IN endpoint head
//  rx_empty     out  1   IN endpoint empty
//  proto_err    out  1   sticky: illegal/dropped strobe or local overflow/underflow
// BEHAVIOUR
//  Reset: both endpoints empty, FLAG_EMPTY=1, FLAG_FULL=0, tx_full=0, rx_empty=1, rx_q=0, proto_err=0,
//   FD=Z. Applies immediately, mid-transfer included; partial packets are discarded.
//  All strobes are sampled on posedge CLK, level-qualified, one word per strobed cycle; no handshake latency.
//  Flags/counts: registered; a push or pop sampled at edge N is reflected in the flags after edge N.
//   A master sampling FLAG_EMPTY on the same edge as its SLRD sees the pre-pop value.
//  FD drive: responder drives FD = OUT head iff SLOE=1 && FIFOADR==00.
//   Drives 16'h0000 if OUT is empty; otherwise FD=Z. Combinational from SLOE/FIFOADR/head.
//  Read: SLRD=1 && FIFOADR==00 && !FLAG_EMPTY -> pop; the next head appears on FD one cycle later.
//   SLRD with empty OUT or wrong FIFOADR: no pop, proto_err<=1.
//  Write: SLWR=1 && FIFOADR==10 && !FLAG_FULL -> push {PKTEND,FD}.
//   Wrong FIFOADR, full, or SLOE=1 (bus not driven by master): drop, proto_err<=1.
//  PKTEND without a valid SLWR: ignored, proto_err<=1.
//  SLRD and SLWR in the same cycle: both evaluated independently; only the one matching FIFOADR is legal,
//   the other sets proto_err.
//  Local side: tx_wrreq when tx_full -> drop, proto_err; rx_rdrq when rx_empty -> no-op, proto_err.
//  Simultaneous push+pop on one endpoint (any fill level incl. full/empty boundary per FWFT rules):
//   count unchanged, both take effect. Push to an empty FWFT endpoint is visible at head one cycle later.
//  Pointers are AW bits and wrap modulo 2^AW. Count is AW+1 bits; full = count==2^AW.
//  FIFOADR 01/11: no drive, all strobes illegal.
// STRUCTURE
//  Package slave_fifo_pkg: ADR_OUT=2'b00, ADR_IN=2'b10, DW, default AW.
//  Sub-module sync_fwft_fifo #(AW,W): one clock, async active-low reset, wrreq/data/rdrq/q/empty/full/count.
//   Instantiated twice: OUT with W=16, IN with W=17.
//  Top holds strobe qualification, FD tristate, and the proto_err register.
// TESTING
//  T1 Reset: hold RST=0 -> FLAG_EMPTY=1, FLAG_FULL=0, FD=Z, proto_err=0.
//  T2 Master read: push 3 words A001,A002,A003 via tx, SLOE=1, FIFOADR=00, SLRD 3 cycles
//   -> FD shows A001,A002,A003 in order; FLAG_EMPTY=1 after third pop; proto_err=0.
//  T3 Master write with PKTEND: FIFOADR=10, SLWR on B001,B002 (PKTEND on second)
//   -> rx_q = 0_B001 then 1_B002, rx_empty after 2 pops.
//  T4 Full boundary: 512 SLWR -> FLAG_FULL=1; 513th SLWR dropped, proto_err=1;
//   then rx_rdrq and SLWR in the same cycle -> FLAG_FULL stays 1, count 512.
//  T5 Illegal: SLRD with OUT empty, SLWR with FIFOADR=00, PKTEND alone
//   -> no pointer change, proto_err=1 each (check after reset between cases).
//  T6 Reset mid-burst: assert RST during a T2 read of 100 words
//   -> immediate empty flags, FD=Z, clean restart on next burst.

Source files
------------

// File: rtl/slave_fifo_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : slave_fifo_pkg
//  Brief   : Shared constants for the slave-FIFO bus responder.
//  Revision: 1.0
// ============================================================================
package slave_fifo_pkg;

    localparam int DW         = 16;
    localparam int AW_DEFAULT = 9;

    typedef enum logic [1:0] {
        ADR_OUT  = 2'b00,
        ADR_RSV1 = 2'b01,
        ADR_IN   = 2'b10,
        ADR_RSV3 = 2'b11
    } fifoadr_e;

endpackage : slave_fifo_pkg
`default_nettype wire

// File: rtl/slave_fifo_responder_fifo.sv
`default_nettype none
// ============================================================================
//  Module  : sync_fwft_fifo
//  Brief   : Single-clock first-word-fall-through FIFO with occupancy count.
//  Revision: 1.0
// ============================================================================
module sync_fwft_fifo #(
    parameter int AW = 9,
    parameter int W  = 16
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_wrreq,
    input  logic [W-1:0]  i_data,
    input  logic          i_rdrq,
    output logic [W-1:0]  o_q,
    output logic          o_empty,
    output logic          o_full,
    output logic [AW:0]   o_count
);

    localparam int            c_DEPTH      = 1 << AW;
    localparam logic [AW:0]   c_FULL_COUNT = {1'b1, {AW{1'b0}}};

    logic [W-1:0]  r_mem [0:c_DEPTH-1];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_empty;
    logic          w_full;
    logic          w_wr;
    logic          w_rd;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_FULL_COUNT);

    // A write into a full FIFO is legal when a read frees the slot on the same edge.
    assign w_rd = i_rdrq && !w_empty;
    assign w_wr = i_wrreq && (!w_full || w_rd);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_q     = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_empty = w_empty;
    assign o_full  = w_full;
    assign o_count = r_count;

endmodule : sync_fwft_fifo
`default_nettype wire

// File: rtl/slave_fifo_responder.sv
`default_nettype none
// ============================================================================
//  Module  : slave_fifo_responder
//  Brief   : Target side of the 16-bit synchronous slave-FIFO bus with one
//            OUT (master reads) and one IN (master writes) endpoint.
//  Revision: 1.0
// ============================================================================
module slave_fifo_responder
    import slave_fifo_pkg::*;
#(
    parameter int AW = AW_DEFAULT
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_sloe,
    input  logic           i_slrd,
    input  logic           i_slwr,
    input  logic [1:0]     i_fifoadr,
    input  logic           i_pktend,
    inout  wire  [DW-1:0]  io_fd,
    output logic           o_fd_oe,
    output logic           o_flag_empty,
    output logic           o_flag_full,
    input  logic [DW-1:0]  i_tx_data,
    input  logic           i_tx_wrreq,
    output logic           o_tx_full,
    output logic [AW:0]    o_tx_count,
    output logic [DW:0]    o_rx_q,
    input  logic           i_rx_rdrq,
    output logic           o_rx_empty,
    output logic [AW:0]    o_rx_count,
    output logic           o_proto_err
);

    logic [DW-1:0] w_out_head;
    logic          w_out_empty;
    logic          w_out_full;
    logic          w_in_empty;
    logic          w_in_full;
    logic          w_out_pop;
    logic          w_out_push;
    logic          w_in_pop;
    logic          w_in_push;
    logic          w_fd_oe;
    logic          w_err;
    logic          r_proto_err;

    assign w_out_pop  = i_slrd && (i_fifoadr == ADR_OUT) && !w_out_empty;
    assign w_in_pop   = i_rx_rdrq && !w_in_empty;
    // SLOE=1 means the master is not driving FD, so a write strobe then carries no data.
    assign w_in_push  = i_slwr && (i_fifoadr == ADR_IN) && !i_sloe
                        && (!w_in_full || w_in_pop);
    assign w_out_push = i_tx_wrreq && (!w_out_full || w_out_pop);

    assign w_err = (i_slrd     && !w_out_pop)
                 | (i_slwr     && !w_in_push)
                 | (i_pktend   && !w_in_push)
                 | (i_tx_wrreq && !w_out_push)
                 | (i_rx_rdrq  && !w_in_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_proto_err <= 1'b0;
        end else if (w_err) begin
            r_proto_err <= 1'b1;
        end
    end

    sync_fwft_fifo #(.AW(AW), .W(DW)) u_out_ep (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_wrreq (w_out_push),
        .i_data  (i_tx_data),
        .i_rdrq  (w_out_pop),
        .o_q     (w_out_head),
        .o_empty (w_out_empty),
        .o_full  (w_out_full),
        .o_count (o_tx_count)
    );

    sync_fwft_fifo #(.AW(AW), .W(DW + 1)) u_in_ep (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_wrreq (w_in_push),
        .i_data  ({i_pktend, io_fd}),
        .i_rdrq  (w_in_pop),
        .o_q     (o_rx_q),
        .o_empty (w_in_empty),
        .o_full  (w_in_full),
        .o_count (o_rx_count)
    );

    // Bus is released while in reset; the OUT head already reads as zero when empty.
    assign w_fd_oe = i_rst_n && i_sloe && (i_fifoadr == ADR_OUT);
    assign io_fd   = w_fd_oe ? w_out_head : {DW{1'bz}};

    assign o_fd_oe      = w_fd_oe;
    assign o_flag_empty = w_out_empty;
    assign o_flag_full  = w_in_full;
    assign o_tx_full    = w_out_full;
    assign o_rx_empty   = w_in_empty;
    assign o_proto_err  = r_proto_err;

endmodule : slave_fifo_responder
`default_nettype wire

// File: tb/tb_slave_fifo_responder.sv
`default_nettype none
// ============================================================================
//  Module  : tb_slave_fifo_responder
//  Brief   : Directed, self-checking bench for slave_fifo_responder.
//  Revision: 1.0
// ============================================================================
module tb_slave_fifo_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sloe, slrd, slwr, pktend, tx_wrreq, rx_rdrq;
    logic [1:0]  fifoadr;
    logic [15:0] tx_data;
    logic        tb_fd_en;
    logic [15:0] tb_fd;
    wire  [15:0] fd;
    logic        fd_oe, flag_empty, flag_full, tx_full, rx_empty, proto_err;
    logic [9:0]  tx_count, rx_count;
    logic [16:0] rx_q;

    int n_cmp;
    int n_bad;

    assign fd = tb_fd_en ? tb_fd : 16'bz;

    always #5 clk = ~clk;

    slave_fifo_responder #(.AW(9)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_sloe       (sloe),
        .i_slrd       (slrd),
        .i_slwr       (slwr),
        .i_fifoadr    (fifoadr),
        .i_pktend     (pktend),
        .io_fd        (fd),
        .o_fd_oe      (fd_oe),
        .o_flag_empty (flag_empty),
        .o_flag_full  (flag_full),
        .i_tx_data    (tx_data),
        .i_tx_wrreq   (tx_wrreq),
        .o_tx_full    (tx_full),
        .o_tx_count   (tx_count),
        .o_rx_q       (rx_q),
        .i_rx_rdrq    (rx_rdrq),
        .o_rx_empty   (rx_empty),
        .o_rx_count   (rx_count),
        .o_proto_err  (proto_err)
    );

    typedef struct {
        logic        sloe, slrd, slwr;
        logic [1:0]  adr;
        logic        pk;
        logic [15:0] fd;
        logic        txw;
        logic [15:0] txd;
        logic        rxr;
        logic        e_fe, e_ff, e_re;
        logic [16:0] e_rq;
        logic        e_oe;
        logic [15:0] e_fd;
        logic        e_err;
    } vec_t;

    vec_t vt [15];

    function automatic vec_t mk(input logic s_oe, s_rd, s_wr, input logic [1:0] a,
                                input logic p, input logic [15:0] d, input logic tw,
                                input logic [15:0] td, input logic rr,
                                input logic fe, ff, re, input logic [16:0] rq,
                                input logic oe, input logic [15:0] efd, input logic er);
        vec_t v;
        v.sloe = s_oe; v.slrd = s_rd; v.slwr = s_wr; v.adr = a; v.pk = p; v.fd = d;
        v.txw = tw; v.txd = td; v.rxr = rr;
        v.e_fe = fe; v.e_ff = ff; v.e_re = re; v.e_rq = rq; v.e_oe = oe;
        v.e_fd = efd; v.e_err = er;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle();
        sloe = 0; slrd = 0; slwr = 0; pktend = 0; fifoadr = 2'b01;
        tx_wrreq = 0; tx_data = '0; rx_rdrq = 0; tb_fd_en = 0; tb_fd = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        step();
    endtask

    task automatic illegal(input string nm, input logic s_oe, s_rd, s_wr,
                           input logic [1:0] a, input logic p, input logic rr);
        do_reset();
        sloe = s_oe; slrd = s_rd; slwr = s_wr; fifoadr = a; pktend = p; rx_rdrq = rr;
        tb_fd_en = !s_oe; tb_fd = 16'h5A5A;
        step();
        idle();
        chk({nm, " proto_err"}, 32'(proto_err), 32'd1);
        chk({nm, " tx_count"}, 32'(tx_count), 32'd0);
        chk({nm, " rx_count"}, 32'(rx_count), 32'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        idle();
        rst_n = 1'b0;

        // T1: held in reset with the master releasing the bus at the OUT address
        sloe = 1; fifoadr = 2'b00;
        step();
        step();
        chk("rst flag_empty", 32'(flag_empty), 32'd1);
        chk("rst flag_full",  32'(flag_full),  32'd0);
        chk("rst fd_oe",      32'(fd_oe),      32'd0);
        chk("rst proto_err",  32'(proto_err),  32'd0);
        chk("rst rx_empty",   32'(rx_empty),   32'd1);
        chk("rst rx_q",       32'(rx_q),       32'd0);
        chk("rst tx_full",    32'(tx_full),    32'd0);
        idle();
        rst_n = 1'b1;
        step();

        // T2/T3 plus simultaneous push/pop on the OUT endpoint
        //              oe rd wr adr    pk fd       txw txd      rxr fe ff re rq         oe efd      err
        vt[0]  = mk(0, 0, 0, 2'b01, 0, 16'h0000, 1, 16'hA001, 0,  0, 0, 1, 17'h00000, 0, 16'h0000, 0);
        vt[1]  = mk(0, 0, 0, 2'b01, 0, 16'h0000, 1, 16'hA002, 0,  0, 0, 1, 17'h00000, 0, 16'h0000, 0);
        vt[2]  = mk(0, 0, 0, 2'b01, 0, 16'h0000, 1, 16'hA003, 0,  0, 0, 1, 17'h00000, 0, 16'h0000, 0);
        vt[3]  = mk(1, 0, 0, 2'b00, 0, 16'h0000, 0, 16'h0000, 0,  0, 0, 1, 17'h00000, 1, 16'hA001, 0);
        vt[4]  = mk(1, 1, 0, 2'b00, 0, 16'h0000, 0, 16'h0000, 0,  0, 0, 1, 17'h00000, 1, 16'hA002, 0);
        vt[5]  = mk(1, 1, 0, 2'b00, 0, 16'h0000, 0, 16'h0000, 0,  0, 0, 1, 17'h00000, 1, 16'hA003, 0);
        vt[6]  = mk(1, 1, 0, 2'b00, 0, 16'h0000, 0, 16'h0000, 0,  1, 0, 1, 17'h00000, 1, 16'h0000, 0);
        vt[7]  = mk(0, 0, 1, 2'b10, 0, 16'hB001, 0, 16'h0000, 0,  1, 0, 0, 17'h0B001, 0, 16'h0000, 0);
        vt[8]  = mk(0, 0, 1, 2'b10, 1, 16'hB002, 0, 16'h0000, 0,  1, 0, 0, 17'h0B001, 0, 16'h0000, 0);
        vt[9]  = mk(0, 0, 0, 2'b10, 0, 16'h0000, 0, 16'h0000, 1,  1, 0, 0, 17'h1B002, 0, 16'h0000, 0);
        vt[10] = mk(0, 0, 0, 2'b10, 0, 16'h0000, 0, 16'h0000, 1,  1, 0, 1, 17'h00000, 0, 16'h0000, 0);
        vt[11] = mk(1, 0, 0, 2'b00, 0, 16'h0000, 1, 16'hC001, 0,  0, 0, 1, 17'h00000, 1, 16'hC001, 0);
        vt[12] = mk(1, 1, 0, 2'b00, 0, 16'h0000, 1, 16'hC002, 0,  0, 0, 1, 17'h00000, 1, 16'hC002, 0);
        vt[13] = mk(1, 1, 0, 2'b00, 0, 16'h0000, 0, 16'h0000, 0,  1, 0, 1, 17'h00000, 1, 16'h0000, 0);
        vt[14] = mk(1, 1, 0, 2'b00, 0, 16'h0000, 0, 16'h0000, 0,  1, 0, 1, 17'h00000, 1, 16'h0000, 1);

        for (int i = 0; i < 15; i++) begin
            sloe = vt[i].sloe; slrd = vt[i].slrd; slwr = vt[i].slwr; fifoadr = vt[i].adr;
            pktend = vt[i].pk; tb_fd = vt[i].fd; tb_fd_en = !vt[i].sloe;
            tx_wrreq = vt[i].txw; tx_data = vt[i].txd; rx_rdrq = vt[i].rxr;
            step();
            chk($sformatf("v%0d flag_empty", i), 32'(flag_empty), 32'(vt[i].e_fe));
            chk($sformatf("v%0d flag_full", i),  32'(flag_full),  32'(vt[i].e_ff));
            chk($sformatf("v%0d rx_empty", i),   32'(rx_empty),   32'(vt[i].e_re));
            chk($sformatf("v%0d rx_q", i),       32'(rx_q),       32'(vt[i].e_rq));
            chk($sformatf("v%0d fd_oe", i),      32'(fd_oe),      32'(vt[i].e_oe));
            if (vt[i].e_oe)
                chk($sformatf("v%0d fd", i),     32'(fd),         32'(vt[i].e_fd));
            chk($sformatf("v%0d proto_err", i),  32'(proto_err),  32'(vt[i].e_err));
        end
        idle();

        // T4: fill IN endpoint, overflow, then read+write at the full boundary
        do_reset();
        for (int i = 0; i < 512; i++) begin
            fifoadr = 2'b10; slwr = 1; tb_fd_en = 1; tb_fd = 16'(i);
            step();
        end
        idle();
        step();
        chk("full flag_full", 32'(flag_full), 32'd1);
        chk("full rx_count",  32'(rx_count),  32'd512);
        chk("full proto_err", 32'(proto_err), 32'd0);
        fifoadr = 2'b10; slwr = 1; tb_fd_en = 1; tb_fd = 16'hFFFF;
        step();
        idle();
        chk("ovf proto_err",  32'(proto_err), 32'd1);
        chk("ovf rx_count",   32'(rx_count),  32'd512);
        fifoadr = 2'b10; slwr = 1; tb_fd_en = 1; tb_fd = 16'h1234; rx_rdrq = 1;
        step();
        idle();
        chk("rw flag_full",   32'(flag_full), 32'd1);
        chk("rw rx_count",    32'(rx_count),  32'd512);
        chk("rw rx_q",        32'(rx_q),      32'h00001);

        // T5: illegal strobes, each from a fresh reset
        illegal("slrd empty",    0, 1, 0, 2'b00, 0, 0);
        illegal("slwr adr00",    0, 0, 1, 2'b00, 0, 0);
        illegal("pktend alone",  0, 0, 0, 2'b10, 1, 0);
        illegal("slwr sloe",     1, 0, 1, 2'b10, 0, 0);
        illegal("slwr adr11",    0, 0, 1, 2'b11, 0, 0);
        illegal("rx_rdrq empty", 0, 0, 0, 2'b01, 0, 1);

        // T6: reset in the middle of a 100-word read burst
        do_reset();
        for (int i = 0; i < 100; i++) begin
            tx_wrreq = 1; tx_data = 16'h6000 + 16'(i);
            step();
        end
        idle();
        chk("burst tx_count", 32'(tx_count), 32'd100);
        sloe = 1; fifoadr = 2'b00; slrd = 1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("burst fd%0d", i), 32'(fd), 32'h6000 + 32'(i + 1));
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst flag_empty", 32'(flag_empty), 32'd1);
        chk("midrst fd_oe",      32'(fd_oe),      32'd0);
        chk("midrst tx_count",   32'(tx_count),   32'd0);
        chk("midrst proto_err",  32'(proto_err),  32'd0);
        slrd = 0;
        #1;
        rst_n = 1'b1;
        step();
        sloe = 0; fifoadr = 2'b01;
        for (int i = 0; i < 3; i++) begin
            tx_wrreq = 1; tx_data = 16'hE001 + 16'(i);
            step();
        end
        tx_wrreq = 0;
        sloe = 1; fifoadr = 2'b00;
        #1;
        chk("restart fd0", 32'(fd), 32'h0000E001);
        slrd = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("restart fd%0d", i + 1), 32'(fd),
                (i < 2) ? 32'h0000E002 + 32'(i) : 32'd0);
        end
        idle();
        chk("restart flag_empty", 32'(flag_empty), 32'd1);
        chk("restart proto_err",  32'(proto_err),  32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_slave_fifo_responder
`default_nettype wire
